// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID stage and the hazard scoreboard: the decoded ID
// instruction, the global pipeline controls, and the stall/forwarding results.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  src1;
    logic [REG_ADDR_W-1:0]  src2;
    logic                   is_im;
    logic [REG_ADDR_W-1:0]  id_dest;
    logic                   id_wb_en;
    logic                   id_mem_r_en;
    logic                   freeze;
    logic                   flush;
    logic                   hazard_detected;
    logic [2:0]             fwd_sel1;
    logic [2:0]             fwd_sel2;
    logic [STALL_CNT_W-1:0] stall_count;

    // ID-stage side: presents the instruction, consumes stall and forwarding
    modport master (
        output id_valid, src1, src2, is_im, id_dest, id_wb_en, id_mem_r_en,
        output freeze, flush,
        input  hazard_detected, fwd_sel1, fwd_sel2, stall_count
    );

    // Scoreboard side
    modport slave (
        input  id_valid, src1, src2, is_im, id_dest, id_wb_en, id_mem_r_en,
        input  freeze, flush,
        output hazard_detected, fwd_sel1, fwd_sel2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit beside ID. Keeps a shadow pipeline of in-flight
// destinations, raises the ID stall, picks per-operand forwarding sources
// and counts hazard stall cycles (saturating).
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int PIPE_DEPTH  = 2,
    parameter int FWD_EN      = 0,
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic                  wbEn;
        logic                  memREn;
        logic [REG_ADDR_W-1:0] dest;
    } entry_t;

    // Index 0 is the instruction now in EXE, higher indices are older.
    entry_t entry_q [PIPE_DEPTH];
    entry_t entry_d [PIPE_DEPTH];

    logic [STALL_CNT_W-1:0] stallCount_q;
    logic [STALL_CNT_W-1:0] stallCount_d;

    logic       hazardDetected;
    logic [2:0] youngest1;
    logic [2:0] youngest2;
    logic [2:0] fwdSel1;
    logic [2:0] fwdSel2;
    logic       src1Hazard;
    logic       src2Hazard;

    function automatic logic entryMatch(input entry_t e, input logic [REG_ADDR_W-1:0] src);
        return e.valid && e.wbEn && (e.dest == src);
    endfunction

    // Find the youngest producer of each operand and turn it into a stall or forward
    always_comb begin
        youngest1  = 3'd0;
        youngest2  = 3'd0;
        src1Hazard = 1'b0;
        src2Hazard = 1'b0;
        fwdSel1    = 3'd0;
        fwdSel2    = 3'd0;
        if (bus.id_valid) begin
            // Walk oldest to youngest so the youngest match is the one left standing
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                if (entryMatch(entry_q[k], bus.src1)) begin
                    youngest1 = 3'(k + 1);
                end
                if (!bus.is_im && entryMatch(entry_q[k], bus.src2)) begin
                    youngest2 = 3'(k + 1);
                end
            end
        end
        if (FWD_EN == 0) begin
            src1Hazard = (youngest1 != 3'd0);
            src2Hazard = (youngest2 != 3'd0);
        end else begin
            // Only a load still in EXE cannot be forwarded in time
            src1Hazard = (youngest1 == 3'd1) && entry_q[0].memREn;
            src2Hazard = (youngest2 == 3'd1) && entry_q[0].memREn;
            fwdSel1    = src1Hazard ? 3'd0 : youngest1;
            fwdSel2    = src2Hazard ? 3'd0 : youngest2;
        end
        hazardDetected = bus.id_valid && (src1Hazard || src2Hazard);
    end

    // Advance the shadow pipeline and stall counter unless the pipeline is frozen
    always_comb begin
        entry_d      = entry_q;
        stallCount_d = stallCount_q;
        if (!bus.freeze) begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                entry_d[k] = entry_q[k - 1];
            end
            entry_d[0] = '0;
            if (bus.id_valid && !hazardDetected && !bus.flush) begin
                entry_d[0] = '{valid: 1'b1, wbEn: bus.id_wb_en,
                               memREn: bus.id_mem_r_en, dest: bus.id_dest};
            end
            if (hazardDetected && !bus.flush && (stallCount_q != '1)) begin
                stallCount_d = stallCount_q + STALL_CNT_W'(1);
            end
        end
    end

    // State registers; reset outranks freeze and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                entry_q[k] <= '0;
            end
            stallCount_q <= '0;
        end else begin
            entry_q      <= entry_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign bus.hazard_detected = hazardDetected;
    assign bus.fwd_sel1        = fwdSel1;
    assign bus.fwd_sel2        = fwdSel2;
    assign bus.stall_count     = stallCount_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: one stall-only and one forwarding scoreboard, both with a
// two-stage shadow pipeline, driven with the same ID stream.
module tb_hazard_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) ifStall ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) ifFwd ();

    hazard_scoreboard #(.REG_ADDR_W(5), .PIPE_DEPTH(2), .FWD_EN(0), .STALL_CNT_W(16)) dutStall (
        .clk (clk),
        .rst (rst),
        .bus (ifStall.slave)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .PIPE_DEPTH(2), .FWD_EN(1), .STALL_CNT_W(16)) dutFwd (
        .clk (clk),
        .rst (rst),
        .bus (ifFwd.slave)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic valid, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic im, input logic [4:0] dest, input logic wb,
                                 input logic ld, input logic frz, input logic fl);
        ifStall.id_valid    = valid;  ifFwd.id_valid    = valid;
        ifStall.src1        = s1;     ifFwd.src1        = s1;
        ifStall.src2        = s2;     ifFwd.src2        = s2;
        ifStall.is_im       = im;     ifFwd.is_im       = im;
        ifStall.id_dest     = dest;   ifFwd.id_dest     = dest;
        ifStall.id_wb_en    = wb;     ifFwd.id_wb_en    = wb;
        ifStall.id_mem_r_en = ld;     ifFwd.id_mem_r_en = ld;
        ifStall.freeze      = frz;    ifFwd.freeze      = frz;
        ifStall.flush       = fl;     ifFwd.flush       = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        stepClock();
        stepClock();
        rst = 1'b0;

        // Idle after reset: everything quiet
        for (int i = 0; i < 3; i++) begin
            idle();
            #1;
            checkOutput("idle_haz_s",  32'(ifStall.hazard_detected), 0);
            checkOutput("idle_sel1_s", 32'(ifStall.fwd_sel1), 0);
            checkOutput("idle_sel2_s", 32'(ifStall.fwd_sel2), 0);
            checkOutput("idle_cnt_s",  32'(ifStall.stall_count), 0);
            checkOutput("idle_haz_f",  32'(ifFwd.hazard_detected), 0);
            checkOutput("idle_cnt_f",  32'(ifFwd.stall_count), 0);
            stepClock();
        end

        // ADD r3 then SUB r4,r3,r1 back to back
        applyStimulus(1, 1, 2, 0, 3, 1, 0, 0, 0);
        #1;
        checkOutput("add_haz_s", 32'(ifStall.hazard_detected), 0);
        stepClock();
        applyStimulus(1, 3, 1, 0, 4, 1, 0, 0, 0);
        #1;
        checkOutput("raw_c1_haz_s",  32'(ifStall.hazard_detected), 1);
        checkOutput("raw_c1_sel1_s", 32'(ifStall.fwd_sel1), 0);
        checkOutput("alu_use_haz_f", 32'(ifFwd.hazard_detected), 0);
        checkOutput("alu_use_sel1_f", 32'(ifFwd.fwd_sel1), 1);
        stepClock();
        #1;
        checkOutput("raw_c2_haz_s", 32'(ifStall.hazard_detected), 1);
        checkOutput("raw_c2_cnt_s", 32'(ifStall.stall_count), 1);
        stepClock();
        #1;
        checkOutput("raw_c3_haz_s", 32'(ifStall.hazard_detected), 0);
        checkOutput("raw_c3_cnt_s", 32'(ifStall.stall_count), 2);
        stepClock();
        doReset();

        // LDR r5 then ADD r6,r5,r5
        applyStimulus(1, 1, 1, 0, 5, 1, 1, 0, 0);
        #1;
        checkOutput("ldr_haz_f", 32'(ifFwd.hazard_detected), 0);
        stepClock();
        applyStimulus(1, 5, 5, 0, 6, 1, 0, 0, 0);
        #1;
        checkOutput("ld_use_haz_f", 32'(ifFwd.hazard_detected), 1);
        stepClock();
        #1;
        checkOutput("ld_use_after_haz_f",  32'(ifFwd.hazard_detected), 0);
        checkOutput("ld_use_after_sel1_f", 32'(ifFwd.fwd_sel1), 2);
        checkOutput("ld_use_after_sel2_f", 32'(ifFwd.fwd_sel2), 2);
        checkOutput("ld_use_cnt_f",        32'(ifFwd.stall_count), 1);
        stepClock();

        // ADD r7 then SUB r8,r7,#4 with src2 aliasing r7 but ignored
        applyStimulus(1, 1, 1, 0, 7, 1, 0, 0, 0);
        #1;
        checkOutput("add_r7_haz_f", 32'(ifFwd.hazard_detected), 0);
        stepClock();
        applyStimulus(1, 7, 7, 1, 8, 1, 0, 0, 0);
        #1;
        checkOutput("imm_haz_f",  32'(ifFwd.hazard_detected), 0);
        checkOutput("imm_sel1_f", 32'(ifFwd.fwd_sel1), 1);
        checkOutput("imm_sel2_f", 32'(ifFwd.fwd_sel2), 0);
        checkOutput("imm_cnt_f",  32'(ifFwd.stall_count), 1);
        stepClock();

        // Two producers of r2, youngest must win
        applyStimulus(1, 1, 1, 0, 2, 1, 0, 0, 0);
        stepClock();
        applyStimulus(1, 1, 1, 0, 2, 1, 0, 0, 0);
        stepClock();
        applyStimulus(1, 2, 4, 0, 10, 1, 0, 0, 0);
        #1;
        checkOutput("youngest_sel1_f", 32'(ifFwd.fwd_sel1), 1);
        checkOutput("youngest_sel2_f", 32'(ifFwd.fwd_sel2), 0);
        checkOutput("youngest_haz_f",  32'(ifFwd.hazard_detected), 0);
        stepClock();
        doReset();

        // Freeze in the middle of a RAW stall
        applyStimulus(1, 1, 2, 0, 3, 1, 0, 0, 0);
        stepClock();
        applyStimulus(1, 3, 1, 0, 4, 1, 0, 0, 0);
        #1;
        checkOutput("frz_pre_haz_s", 32'(ifStall.hazard_detected), 1);
        stepClock();
        applyStimulus(1, 3, 1, 0, 4, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("frz_haz_s", 32'(ifStall.hazard_detected), 1);
            checkOutput("frz_cnt_s", 32'(ifStall.stall_count), 1);
            stepClock();
        end
        applyStimulus(1, 3, 1, 0, 4, 1, 0, 0, 0);
        #1;
        checkOutput("frz_rel_haz_s", 32'(ifStall.hazard_detected), 1);
        checkOutput("frz_rel_cnt_s", 32'(ifStall.stall_count), 1);
        stepClock();
        #1;
        checkOutput("frz_done_haz_s", 32'(ifStall.hazard_detected), 0);
        checkOutput("frz_done_cnt_s", 32'(ifStall.stall_count), 2);
        stepClock();
        doReset();

        // Flushed writer of r9 must never reach the tracker
        applyStimulus(1, 1, 1, 0, 9, 1, 0, 0, 1);
        #1;
        checkOutput("flush_haz_s", 32'(ifStall.hazard_detected), 0);
        stepClock();
        applyStimulus(1, 9, 9, 0, 11, 1, 0, 0, 0);
        #1;
        checkOutput("post_flush_haz_s",  32'(ifStall.hazard_detected), 0);
        checkOutput("post_flush_haz_f",  32'(ifFwd.hazard_detected), 0);
        checkOutput("post_flush_sel1_f", 32'(ifFwd.fwd_sel1), 0);
        checkOutput("post_flush_sel2_f", 32'(ifFwd.fwd_sel2), 0);
        stepClock();

        // Reset in the middle of a stall
        idle();
        stepClock();
        applyStimulus(1, 1, 2, 0, 3, 1, 0, 0, 0);
        stepClock();
        applyStimulus(1, 3, 1, 0, 4, 1, 0, 0, 0);
        #1;
        checkOutput("rst_pre_haz_s", 32'(ifStall.hazard_detected), 1);
        stepClock();
        #1;
        checkOutput("rst_pre_cnt_s", 32'(ifStall.stall_count), 1);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        #1;
        checkOutput("rst_post_haz_s", 32'(ifStall.hazard_detected), 0);
        checkOutput("rst_post_cnt_s", 32'(ifStall.stall_count), 0);
        stepClock();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
